// File: rtl/uart_tx_fifo.sv
// Buffered UART transmit port: bus writes fill a byte FIFO that drains over the uart sendReq/ready handshake.
// Bus completes in one cycle; writes to a full FIFO are dropped and flag overflow; each sent byte waits for uart ready.
module uart_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int HOLDOFF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic        bus_addr,
  input  logic [7:0]  bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_ready,
  output logic        fifo_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    hold_cnt;
  logic          overflow;
  logic          full, empty;
  logic          data_wr, stat_wr, push, pop;
  logic [31:0]   status;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign fifo_empty = empty;

  // Full is judged on the registered count, so a same-cycle pop never rescues a write.
  assign data_wr = bus_valid & bus_write & ~bus_addr;
  assign stat_wr = bus_valid & bus_write & bus_addr;
  assign push    = data_wr & ~full;
  assign pop     = (state == IDLE) & ~empty & tx_ready;

  assign status = {16'h0, 8'(count), 4'h0, overflow, full, empty, empty & (state == IDLE)};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (data_wr && full)
        overflow <= 1'b1;
      else if (stat_wr && bus_wdata[3])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_ready <= 1'b0;
      bus_rdata <= 32'h0;
    end else begin
      bus_ready <= bus_valid;
      if (bus_valid && !bus_write)
        bus_rdata <= bus_addr ? status : 32'h0;
    end
  end

  // Drain FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = SEND;
      SEND:    state_nxt = HOLD;
      HOLD:    if (hold_cnt <= 4'd1) state_nxt = WAIT;
      WAIT:    if (tx_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_send = (state == SEND);
  end

  // HOLD lasts HOLDOFF cycles, masking the uart's late ready drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      tx_data  <= 8'h0;
    end else begin
      if (pop) tx_data <= mem[rd_ptr];
      if (state == SEND)
        hold_cnt <= 4'(HOLDOFF);
      else if (state == HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH 16, HOLDOFF 2) with a simple uart ready model.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_valid = 1'b0;
  logic        bus_write = 1'b0;
  logic        bus_addr = 1'b0;
  logic [7:0]  bus_wdata = 8'h0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_ready;
  logic        fifo_empty;

  logic        uart_model = 1'b0;
  logic        force_ready = 1'b1;
  logic        model_rdy = 1'b1;
  int          busy = 0;
  int          busy_len = 20;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  sent_dat[$];
  int          sent_cyc[$];

  assign tx_ready = uart_model ? model_rdy : force_ready;

  uart_tx_fifo #(.DEPTH(16), .HOLDOFF(2)) dut (
    .clk(clk), .reset(reset),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready),
    .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // uart model: ready drops the cycle sendReq is seen and stays low busy_len cycles
  always @(negedge clk) begin
    if (tx_send) begin
      sent_dat.push_back(tx_data);
      sent_cyc.push_back(cyc);
      busy = busy_len;
    end else if (busy > 0) begin
      busy--;
    end
    model_rdy = (busy == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] d);
    @(negedge clk);
    bus_valid = 1'b1; bus_write = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_valid = 1'b0; bus_write = 1'b0;
    chk("wr_ready", 32'(bus_ready), 32'd1);
  endtask

  task automatic bus_rd(input logic a, output logic [31:0] d);
    @(negedge clk);
    bus_valid = 1'b1; bus_write = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_valid = 1'b0;
    chk("rd_ready", 32'(bus_ready), 32'd1);
    d = bus_rdata;
  endtask

  task automatic wait_sent(input int n, input int budget);
    for (int i = 0; i < budget && sent_dat.size() < n; i++) @(negedge clk);
    chk("send_timeout", 32'(sent_dat.size() >= n), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int base;
    int nb;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_bus_ready", 32'(bus_ready), 32'd0);
    chk("rst_bus_rdata", bus_rdata, 32'h0);
    chk("rst_tx_send", 32'(tx_send), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    reset = 1'b0;

    // Status after reset, single-cycle ready pulse, rdata holds
    bus_rd(1'b1, rd);
    chk("status_reset", rd, 32'h3);
    @(negedge clk);
    chk("ready_pulse_len", 32'(bus_ready), 32'd0);
    chk("rdata_hold", bus_rdata, 32'h3);

    // Two bytes through the uart model
    uart_model = 1'b1;
    busy_len = 20;
    base = sent_dat.size();
    bus_wr(1'b0, 8'h48);
    bus_wr(1'b0, 8'h69);
    wait_sent(base + 2, 300);
    chk("hi_byte0", 32'(sent_dat[base]), 32'h48);
    chk("hi_byte1", 32'(sent_dat[base+1]), 32'h69);
    chk("hi_gap_ge20", 32'((sent_cyc[base+1] - sent_cyc[base]) >= 20), 32'd1);
    repeat (40) @(negedge clk);
    chk("hi_empty", 32'(fifo_empty), 32'd1);
    bus_rd(1'b0, rd);
    chk("data_read_zero", rd, 32'h0);

    // Overflow: 17 writes with uart stalled
    uart_model = 1'b0;
    force_ready = 1'b0;
    base = sent_dat.size();
    for (int i = 0; i < 17; i++) bus_wr(1'b0, 8'(i));
    bus_rd(1'b1, rd);
    chk("status_full_ovf", rd, 32'h0000100C);
    chk("full_not_empty", 32'(fifo_empty), 32'd0);
    uart_model = 1'b1;
    wait_sent(base + 16, 1500);
    repeat (100) @(negedge clk);
    chk("ovf_sent_count", 32'(sent_dat.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) chk("ovf_order", 32'(sent_dat[base+i]), 32'(i));

    // Overflow sticky until cleared through STATUS
    bus_rd(1'b1, rd);
    chk("ovf_sticky", rd, 32'h0000000B);
    bus_wr(1'b1, 8'h08);
    bus_rd(1'b1, rd);
    chk("ovf_cleared", rd, 32'h3);

    // Fast uart: 12 fillers move pointers to 14, then 5 bytes across the wrap
    busy_len = 2;
    base = sent_dat.size();
    for (int i = 0; i < 12; i++) bus_wr(1'b0, 8'hA0 + 8'(i));
    wait_sent(base + 12, 500);
    repeat (20) @(negedge clk);
    chk("filler_count", 32'(sent_dat.size() - base), 32'd12);
    base = sent_dat.size();
    for (int i = 0; i < 5; i++) bus_wr(1'b0, 8'hB0 + 8'(i));
    wait_sent(base + 5, 300);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 5; i++) chk("wrap_order", 32'(sent_dat[base+i]), 32'hB0 + 32'(i));
    bus_rd(1'b1, rd);
    chk("wrap_status", rd, 32'h3);

    // Push and pop on the same edge with count = 1
    uart_model = 1'b0;
    force_ready = 1'b0;
    repeat (3) @(negedge clk);
    base = sent_dat.size();
    bus_wr(1'b0, 8'hC1);
    @(negedge clk);
    force_ready = 1'b1;
    bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 1'b0; bus_wdata = 8'hC2;
    @(negedge clk);
    bus_valid = 1'b0; bus_write = 1'b0;
    chk("pp_wr_ready", 32'(bus_ready), 32'd1);
    chk("pp_send_c1", 32'(tx_send), 32'd1);
    bus_rd(1'b1, rd);
    chk("pp_status_cnt1", rd, 32'h00000100);
    repeat (30) @(negedge clk);
    chk("pp_sent_count", 32'(sent_dat.size() - base), 32'd2);
    chk("pp_byte0", 32'(sent_dat[base]), 32'hC1);
    chk("pp_byte1", 32'(sent_dat[base+1]), 32'hC2);
    chk("pp_gap", 32'(sent_cyc[base+1] - sent_cyc[base]), 32'd5);

    // Reset while in HOLD with 3 bytes still queued
    force_ready = 1'b0;
    base = sent_dat.size();
    for (int i = 0; i < 4; i++) bus_wr(1'b0, 8'hD1 + 8'(i));
    @(negedge clk);
    force_ready = 1'b1;
    @(negedge clk);
    chk("mid_send", 32'(tx_send), 32'd1);
    chk("mid_queued", 32'(fifo_empty), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_send", 32'(tx_send), 32'd0);
    chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nb = sent_dat.size();
    chk("mid_one_sent", 32'(nb - base), 32'd1);
    bus_rd(1'b1, rd);
    chk("mid_status", rd, 32'h3);
    repeat (30) @(negedge clk);
    chk("mid_no_more_send", 32'(sent_dat.size()), 32'(nb));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
